pixel_write_arbiter: RTL

Downstream stage of the pixel computation block. It accepts up to CORES_COUNT pixel writes per cycle, one from each PPU lane. It buffers them in per-lane FIFOs and serialises them through round-robin arbitration onto a single Avalon-MM-style framebuffer write master. It also reports when all writes for a frame have drained to memory.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/pixel_lane_fifo.sv | 65 ++++++
 rtl/pixel_write_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the GPU pixel write path: the buffered write record and
// band geometry helpers.
package gpu_pkg;

    localparam int unsigned PIX_ADDR_W  = 32;
    localparam int unsigned PIX_COLOR_W = 16;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0]  addr;
        logic [PIX_COLOR_W-1:0] data;
    } pixel_write_t;

    function automatic int unsigned lines_per_ppu(input int unsigned y_size,
                                                  input int unsigned cores);
        return y_size / cores;
    endfunction

endpackage

// File: rtl/pixel_lane_fifo.sv
// Per-lane synchronous FIFO of pixel writes; a push while full is accepted
// when a pop happens in the same cycle.
module pixel_lane_fifo
    import gpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  pixel_write_t     wdata,
    input  logic             pop,
    output pixel_write_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    pixel_write_t     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Buffers per-lane PPU pixel writes and serialises them round-robin onto a
// single framebuffer write master; reports when a frame has fully drained.
module pixel_write_arbiter
    import gpu_pkg::*;
#(
    parameter int unsigned CORES_COUNT     = 10,
    parameter int unsigned COLOR_WIDTH     = PIX_COLOR_W,
    parameter int unsigned BUFFER_ADDR_W   = PIX_ADDR_W,
    parameter int unsigned SCREEN_X_SIZE   = 800,
    parameter int unsigned SCREEN_Y_SIZE   = 600,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned FB_BASE         = 0,
    parameter int unsigned BYTES_PER_PIXEL = 2
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic [CORES_COUNT-1:0][COLOR_WIDTH-1:0]   ppu_data,
    input  logic [CORES_COUNT-1:0][BUFFER_ADDR_W-1:0] ppu_address,
    input  logic [CORES_COUNT-1:0]                    ppu_valid,
    input  logic                                      frame_eoc,
    output logic [BUFFER_ADDR_W-1:0]                  mem_address,
    output logic [COLOR_WIDTH-1:0]                    mem_writedata,
    output logic                                      mem_write,
    input  logic                                      mem_waitrequest,
    output logic [CORES_COUNT-1:0]                    overflow,
    input  logic                                      clear_overflow,
    output logic                                      frame_done,
    output logic                                      busy
);

    localparam int unsigned LINES_PER_PPU = lines_per_ppu(SCREEN_Y_SIZE, CORES_COUNT);
    localparam int unsigned PTR_W         = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
    localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1;

    logic [CORES_COUNT-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty, lane_active;
    pixel_write_t           fifo_wdata [CORES_COUNT];
    pixel_write_t           fifo_rdata [CORES_COUNT];
    logic [CNT_W-1:0]       fifo_count [CORES_COUNT];

    logic                     mem_write_q, mem_write_d;
    logic [BUFFER_ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [COLOR_WIDTH-1:0]   mem_writedata_q, mem_writedata_d;
    logic [CORES_COUNT-1:0]   overflow_q, overflow_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                     eoc_q, done_pending_q, done_pending_d;
    logic                     frame_done_q, frame_done_d;
    logic                     load, grant_valid;
    logic [PTR_W-1:0]         grant_idx;

    for (genvar i = 0; i < CORES_COUNT; i++) begin : g_lane
        localparam logic [BUFFER_ADDR_W-1:0] LaneBase =
            BUFFER_ADDR_W'(i * LINES_PER_PPU * SCREEN_X_SIZE);
        logic [BUFFER_ADDR_W-1:0] pix_index;

        // Address arithmetic deliberately wraps at BUFFER_ADDR_W bits.
        assign pix_index          = LaneBase + ppu_address[i];
        assign fifo_wdata[i].addr = BUFFER_ADDR_W'(FB_BASE)
                                  + pix_index * BUFFER_ADDR_W'(BYTES_PER_PIXEL);
        assign fifo_wdata[i].data = ppu_data[i];
        assign fifo_push[i]       = ppu_valid[i] && (!fifo_full[i] || fifo_pop[i]);
        assign lane_active[i]     = (fifo_count[i] != '0);

        pixel_lane_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_W      (CNT_W)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (fifo_push[i]),
            .wdata   (fifo_wdata[i]),
            .pop     (fifo_pop[i]),
            .rdata   (fifo_rdata[i]),
            .full    (fifo_full[i]),
            .empty   (fifo_empty[i]),
            .count   (fifo_count[i])
        );
    end

    // Round-robin search starts one past the last granted lane.
    always_comb begin
        int unsigned cand;
        grant_valid = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = 0;
        for (int k = 1; k <= int'(CORES_COUNT); k++) begin
            cand = (int'(rr_ptr_q) + k) % CORES_COUNT;
            if (!grant_valid && !fifo_empty[PTR_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    assign load = !mem_write_q || !mem_waitrequest;

    always_comb begin
        fifo_pop        = '0;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        rr_ptr_d        = rr_ptr_q;
        if (load) begin
            mem_write_d = grant_valid;
            if (grant_valid) begin
                fifo_pop[grant_idx] = 1'b1;
                rr_ptr_d            = grant_idx;
                mem_address_d       = fifo_rdata[grant_idx].addr;
                mem_writedata_d     = fifo_rdata[grant_idx].data;
            end
        end
    end

    // A drop in the same cycle as clear_overflow leaves the bit set.
    always_comb begin
        overflow_d = clear_overflow ? '0 : overflow_q;
        overflow_d = overflow_d | (ppu_valid & fifo_full & ~fifo_pop);
    end

    always_comb begin
        frame_done_d   = 1'b0;
        done_pending_d = done_pending_q | eoc_q;
        if (done_pending_q && (&fifo_empty) && !mem_write_q && !(|ppu_valid)) begin
            frame_done_d   = 1'b1;
            done_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            overflow_q      <= '0;
            rr_ptr_q        <= PTR_W'(CORES_COUNT - 1);
            eoc_q           <= 1'b0;
            done_pending_q  <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            overflow_q      <= overflow_d;
            rr_ptr_q        <= rr_ptr_d;
            eoc_q           <= frame_eoc;
            done_pending_q  <= done_pending_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign overflow      = overflow_q;
    assign frame_done    = frame_done_q;
    assign busy          = (|lane_active) | mem_write_q | done_pending_q;

endmodule
